shift_issue_q: RTL and testbench

- Request-buffering stage directly upstream of the 16-bit combinational barrel shifter.
- Accepts shift requests {In, Cnt, Op} on a valid/ready interface and queues them in a DEPTH-entry FIFO.
- Presents the head request to the shifter's inputs, then registers the shifter's output into a result slot with its own valid/ready interface.
- Decouples a stalling consumer from the producer and gives the shifter path a registered output.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_req_fifo.sv | 41 ++++
 rtl/shift_issue_q.sv | 65 ++++++
 tb/tb_shift_issue_q.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: default widths, shifter opcode encodings and the packed request type.
package shift_pkg;
   localparam int N_DEF = 16;
   localparam int C_DEF = 4;
   localparam int O_DEF = 2;
   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;
   typedef struct packed {
      logic [N_DEF-1:0] in;
      logic [C_DEF-1:0] cnt;
      logic [O_DEF-1:0] op;
   } req_t;
endpackage

// File: rtl/shift_req_fifo.sv
// shift_req_fifo: DEPTH-entry circular request buffer with pointers, count and full/empty flags.
module shift_req_fifo #(
   parameter int W     = 22,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   // storage is deliberately left unreset
   always_ff @(posedge clk)
      if (push && !clr) mem[wr_ptr] <= din;
   assign dout  = mem[rd_ptr];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/shift_issue_q.sv
// shift_issue_q: request queue plus registered result slot around an external barrel shifter.
// Optional SHIFT_ISSUE_Q_BYPASS_EN sends a request straight to the shifter when the queue is empty.
module shift_issue_q
   import shift_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int C     = C_DEF,
   parameter int O     = O_DEF,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_in,
   input  logic [C-1:0] req_cnt,
   input  logic [O-1:0] req_op,
   output logic [N-1:0] sh_In,
   output logic [C-1:0] sh_Cnt,
   output logic [O-1:0] sh_Op,
   input  logic [N-1:0] sh_Out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_out
);
   localparam int W = N + C + O;
   logic [W-1:0] head;
   logic full, empty, push, pop, byp, slot_free, cap;
   assign req_ready = !full && !flush;
   assign push      = req_valid && req_ready;
   assign slot_free = !rsp_valid || rsp_ready;
   assign pop       = !empty && slot_free && !flush;
`ifdef SHIFT_ISSUE_Q_BYPASS_EN
   assign byp = empty && push && slot_free;
   assign {sh_In, sh_Cnt, sh_Op} = (empty && push) ? {req_in, req_cnt, req_op} : empty ? '0 : head;
`else
   assign byp = 1'b0;
   assign {sh_In, sh_Cnt, sh_Op} = empty ? '0 : head;
`endif
   assign cap = pop || byp;
   shift_req_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push && !byp),
      .pop   (pop),
      .din   ({req_in, req_cnt, req_op}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_out   <= '0;
      end else if (flush) begin
         rsp_valid <= 1'b0;
      end else if (cap) begin
         rsp_out   <= sh_Out;
         rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
endmodule

// File: tb/tb_shift_issue_q.sv
// tb_shift_issue_q: randomized and directed checks of shift_issue_q against a queue-based model.
module tb_shift_issue_q;
   import shift_pkg::*;
   localparam int DEPTH = 4;
`ifdef SHIFT_ISSUE_Q_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk, rst, flush, req_valid, req_ready, rsp_valid, rsp_ready;
   logic [15:0] req_in, sh_In, sh_Out, rsp_out;
   logic [3:0]  req_cnt, sh_Cnt;
   logic [1:0]  req_op, sh_Op;
   int checks, errors;
   req_t fq[$];
   logic m_v, acc;
   logic [15:0] m_out;

   shift_issue_q #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in(req_in), .req_cnt(req_cnt), .req_op(req_op),
      .sh_In(sh_In), .sh_Cnt(sh_Cnt), .sh_Op(sh_Op), .sh_Out(sh_Out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] shf(input logic [15:0] x, input logic [3:0] c, input logic [1:0] op);
      logic [31:0] xx;
      xx = {x, x} << c;
      case (op)
         OP_ROL:  return xx[31:16];
         OP_SLL:  return x << c;
         OP_SRA:  return 16'($signed(x) >>> c);
         default: return x >> c;
      endcase
   endfunction

   assign sh_Out = shf(sh_In, sh_Cnt, sh_Op);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: drive, check against the model, advance the model, cross the edge
   task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                      input logic rr, input logic fl);
      logic er, push, sf, byp;
      logic [31:0] esh;
      req_t r;
      req_valid = v; req_in = d; req_cnt = c; req_op = o; rsp_ready = rr; flush = fl;
      #1;
      er   = (fq.size() != DEPTH) && !fl;
      push = v && er;
      sf   = !m_v || rr;
      r    = '{in: d, cnt: c, op: o};
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_v));
      if (m_v) chk("rsp_out", 32'(rsp_out), 32'(m_out));
      esh = fq.size() != 0 ? 32'({fq[0].in, fq[0].cnt, fq[0].op}) : (BYP && push) ? 32'({d, c, o}) : 32'(0);
      chk("sh_bus", 32'({sh_In, sh_Cnt, sh_Op}), esh);
      if (fl) begin
         fq.delete();
         m_v = 1'b0;
      end else begin
         byp = BYP && fq.size() == 0 && push && sf;
         if (byp) begin
            m_v = 1'b1; m_out = shf(d, c, o);
         end else if (fq.size() != 0 && sf) begin
            m_out = shf(fq[0].in, fq[0].cnt, fq[0].op); m_v = 1'b1;
            void'(fq.pop_front());
         end else if (m_v && rr) m_v = 1'b0;
         if (push && !byp) fq.push_back(r);
      end
      acc = push;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic rr, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0, 2'h0, rr, 1'b0);
   endtask

   initial begin
      logic [15:0] d, held_out;
      logic [3:0]  c;
      logic [1:0]  o;
      logic hold;
      checks = 0; errors = 0;
      m_v = 1'b0; m_out = '0; hold = 1'b0;
      rst = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_in = '0; req_cnt = '0; req_op = '0;
      #12;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_out", 32'(rsp_out), 32'(0));
      chk("rst_sh_bus", 32'({sh_In, sh_Cnt, sh_Op}), 32'(0));
      @(negedge clk); rst = 1'b1;
      #1 chk("rst_req_ready", 32'(req_ready), 32'(1));
      @(posedge clk); #1;
      // single request latency
      cyc(1'b1, 16'h0001, 4'd4, OP_SLL, 1'b1, 1'b0);
`ifdef SHIFT_ISSUE_Q_BYPASS_EN
      chk("lat_e0_valid", 32'(rsp_valid), 32'(1));
      chk("lat_e0_out", 32'(rsp_out), 32'h0010);
`else
      chk("lat_e0_valid", 32'(rsp_valid), 32'(0));
      idle(1'b1, 1);
      chk("lat_e1_valid", 32'(rsp_valid), 32'(1));
      chk("lat_e1_out", 32'(rsp_out), 32'h0010);
`endif
      idle(1'b1, 2);
      // fill to full with a stalled consumer, then drain in order
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'h8001 + 16'(i), 4'(i + 1), 2'(i), 1'b0, 1'b0);
      chk("full_ready", 32'(req_ready), 32'(0));
      idle(1'b1, 7);
      // back-to-back streaming
      for (int i = 0; i < 32; i++) cyc(1'b1, 16'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b0);
      // backpressure hold
      cyc(1'b1, 16'hA5C3, 4'd3, OP_ROL, 1'b0, 1'b0);
      idle(1'b0, 1);
      held_out = rsp_out;
      idle(1'b0, 3);
      chk("hold_out", 32'(rsp_out), 32'(held_out));
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      idle(1'b1, 8);
      // flush with three queued entries and a pending result
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'h1234 + 16'(i), 4'(i), OP_SRA, 1'b0, 1'b0);
      cyc(1'b1, 16'hFFFF, 4'd1, OP_SRL, 1'b0, 1'b1);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      chk("flush_valid", 32'(rsp_valid), 32'(0));
      chk("flush_ready", 32'(req_ready), 32'(1));
      chk("flush_sh_in", 32'(sh_In), 32'(0));
      idle(1'b1, 2);
      // asynchronous reset between edges while busy
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'($urandom), 4'($urandom), 2'($urandom), 1'b0, 1'b0);
      req_valid = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(rsp_valid), 32'(0));
      chk("arst_out", 32'(rsp_out), 32'(0));
      fq.delete(); m_v = 1'b0; m_out = '0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      idle(1'b1, 4);
      // random mix with flushes and a producer that holds data while stalled
      for (int i = 0; i < 300; i++) begin
         if (!hold) begin
            d = 16'($urandom); c = 4'($urandom); o = 2'($urandom);
         end
         cyc(($urandom % 4) != 0 || hold, d, c, o, 1'($urandom), ($urandom % 40) == 0);
         hold = req_valid && !acc && !flush;
      end
      idle(1'b1, DEPTH + 3);
      chk("drain_valid", 32'(rsp_valid), 32'(0));
      chk("drain_model_empty", 32'(fq.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
